// File: rtl/rvfi_commit_serializer.sv
// RVFI commit serializer: captures up to NR_COMMIT_PORTS records per cycle into a FIFO and
// streams them out one per cycle with sequence numbers. Optional macro: RVFI_SER_TIMESTAMP_EN.
module rvfi_commit_serializer #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 8,
    parameter int REC_W           = 66
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic [NR_COMMIT_PORTS*REC_W-1:0] rvfi_i,
    output logic                             full_o,
    output logic                             rec_valid_o,
    input  logic                             rec_ready_i,
    output logic [REC_W-1:0]                 rec_o,
    output logic [31:0]                      rec_seq_o,
    output logic [31:0]                      drop_cnt_o,
    output logic                             overflow_o
`ifdef RVFI_SER_TIMESTAMP_EN
    ,
    output logic [31:0]                      rec_time_o
`endif
);

    // Record layout: bit 0 = valid, bit 1 = trap, upper bits are payload (pc, insn, ...).
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int SUM_W = PTR_W + 1;

    logic [REC_W-1:0]           mem     [DEPTH];
    logic [31:0]                seq_mem [DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           occ;
    logic [IDX_W-1:0]           rd_idx;
    logic [31:0]                seq_cnt;
    logic [SUM_W-1:0]           cnt;
    logic [SUM_W-1:0]           room;
    logic [SUM_W-1:0]           free;
    logic [SUM_W-1:0]           off     [NR_COMMIT_PORTS];
    logic [IDX_W-1:0]           waddr   [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] cap;
    logic                       empty;
    logic                       pop;
    logic                       push;
    logic                       drop;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [SUM_W-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Compaction: each captured port lands at wr_ptr + (number of captured ports below it).
    always_comb begin
        cnt = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            cap[i]   = rvfi_i[i*REC_W] | rvfi_i[i*REC_W+1];
            off[i]   = cnt;
            waddr[i] = IDX_W'(wr_ptr + off[i][PTR_W-1:0]);
            cnt      = cnt + SUM_W'(cap[i]);
        end
    end

    assign occ    = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign pop    = !empty && rec_ready_i;
    assign room   = SUM_W'(DEPTH) - SUM_W'(occ);
    assign free   = room + SUM_W'(pop);
    assign full_o = room < SUM_W'(NR_COMMIT_PORTS);
    assign push   = !flush_i && (cnt != '0) && (cnt <= free);
    assign drop   = !flush_i && (cnt > free);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            seq_cnt    <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push) wr_ptr <= wr_ptr + cnt[PTR_W-1:0];
            // Dropped groups still consume sequence numbers so the sink can see the gap.
            seq_cnt <= seq_cnt + 32'(cnt);
            if (drop) begin
                drop_cnt_o <= sat_add(drop_cnt_o, cnt);
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (cap[i]) begin
                    mem[waddr[i]]     <= rvfi_i[i*REC_W +: REC_W];
                    seq_mem[waddr[i]] <= seq_cnt + 32'(off[i]);
                end
            end
        end
    end

    // Outputs are gated by empty so they read zero straight after an asynchronous reset.
    assign rec_valid_o = !empty;
    assign rec_o       = empty ? '0 : mem[rd_idx];
    assign rec_seq_o   = empty ? '0 : seq_mem[rd_idx];

`ifdef RVFI_SER_TIMESTAMP_EN
    logic [31:0] cycle_cnt;
    logic [31:0] time_mem [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cycle_cnt <= '0;
        else         cycle_cnt <= cycle_cnt + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (cap[i]) time_mem[waddr[i]] <= cycle_cnt;
            end
        end
    end

    assign rec_time_o = empty ? '0 : time_mem[rd_idx];
`endif

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Self-checking bench for rvfi_commit_serializer against a queue-based reference model.
module tb_rvfi_commit_serializer;
    localparam int NR = 2;
    localparam int DEPTH = 8;
    localparam int RW = 66;

    logic           clk, rst_n, flush, ready;
    logic [NR*RW-1:0] rvfi;
    logic           full, rec_valid, overflow;
    logic [RW-1:0]  rec;
    logic [31:0]    rec_seq, drop_cnt;
`ifdef RVFI_SER_TIMESTAMP_EN
    logic [31:0]    rec_time;
`endif

    rvfi_commit_serializer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH), .REC_W(RW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rvfi_i(rvfi), .full_o(full),
        .rec_valid_o(rec_valid), .rec_ready_i(ready), .rec_o(rec), .rec_seq_o(rec_seq),
        .drop_cnt_o(drop_cnt), .overflow_o(overflow)
`ifdef RVFI_SER_TIMESTAMP_EN
        , .rec_time_o(rec_time)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [RW-1:0] rec; logic [31:0] seq; logic [31:0] tm; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_seq, m_drop, m_tm;
    logic        m_ovf;
    int          checks, errors;

    function automatic logic [RW-1:0] mk(input logic v, input logic t, input logic [31:0] pc,
                                          input logic [31:0] insn);
        return {insn, pc, t, v};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_seq = 0; m_drop = 0; m_tm = 0; m_ovf = 0;
    endtask

    // Reference behaviour for one clock edge, using the inputs currently driven.
    task automatic model_edge();
        logic [RW-1:0] caps[$];
        logic [RW-1:0] r;
        bit pop;
        int free;
        pop = (mq.size() != 0) && ready;
        if (flush) begin
            mq.delete();
            m_tm++;
            return;
        end
        for (int p = 0; p < NR; p++) begin
            r = rvfi[p*RW +: RW];
            if (r[0] || r[1]) caps.push_back(r);
        end
        free = DEPTH - mq.size() + int'(pop);
        if (pop) void'(mq.pop_front());
        if (caps.size() > free) begin
            m_drop = (longint'(m_drop) + caps.size() > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF
                                                                      : m_drop + caps.size();
            m_ovf = 1;
        end else begin
            foreach (caps[k]) mq.push_back('{caps[k], m_seq + k, m_tm});
        end
        m_seq += caps.size();
        m_tm++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 0; flush = 0; ready = 0; rvfi = '0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; ready = 0; rvfi = '0;
        model_reset();
        #2;
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", rec_valid); end
        checks++; if (rec !== '0) begin errors++; $display("FAIL reset_rec: got %h want 0", rec); end
        checks++; if (rec_seq !== 0) begin errors++; $display("FAIL reset_seq: got %0d want 0", rec_seq); end
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_stream();
        ready = 1;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) rvfi = {mk(1, 0, 32'h8000_0004 + 8*k, $urandom), mk(1, 0, 32'h8000_0000 + 8*k, $urandom)};
            else       rvfi = '0;
            tick();
            checks++;
            if (rec_valid !== (mq.size() != 0)) begin
                errors++; $display("FAIL stream_valid: got %0b want %0b", rec_valid, mq.size() != 0);
            end else if (mq.size() != 0) begin
                checks++;
                if (rec !== mq[0].rec || rec_seq !== mq[0].seq) begin
                    errors++; $display("FAIL stream_head: got %h/%0d want %h/%0d", rec, rec_seq, mq[0].rec, mq[0].seq);
                end
                checks++;
                if (rec[33:2] !== 32'h8000_0000 + 4*rec_seq) begin
                    errors++; $display("FAIL stream_pc: got %h want %h", rec[33:2], 32'h8000_0000 + 4*rec_seq);
                end
            end
        end
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL stream_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_sparse();
        logic [RW-1:0] p0, p1;
        logic [31:0]   s0;
        s0 = m_seq;
        p0 = mk(0, 0, 32'hDEAD_0000, 32'h1111_1111);
        p1 = mk(0, 1, 32'h8000_1234, 32'h2222_2222);
        ready = 1;
        rvfi = {p1, p0};
        tick();
        rvfi = '0;
        checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL sparse_valid: got %0b want 1", rec_valid); end
        checks++; if (rec !== p1) begin errors++; $display("FAIL sparse_rec: got %h want %h", rec, p1); end
        checks++; if (rec_seq !== s0) begin errors++; $display("FAIL sparse_seq: got %0d want %0d", rec_seq, s0); end
        tick();
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL sparse_one: got %0b want 0", rec_valid); end
        checks++; if (m_seq !== s0 + 1 || rec === p0) begin errors++; $display("FAIL sparse_port0: got %h seq %0d", rec, m_seq); end
    endtask

    task automatic test_overflow();
        reset_dut();
        for (int c = 1; c <= 5; c++) begin
            rvfi = {mk(1, 0, 32'h100 + 8*c, 0), mk(1, 0, 32'h104 + 8*c, 0)};
            tick();
            if (c == 3) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full3: got %0b want 0", full); end
            end
            if (c == 4) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full4: got %0b want 1", full); end
            end
        end
        rvfi = '0;
        checks++; if (drop_cnt !== 32'd2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
        ready = 1;
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (rec_valid !== 1'b1 || rec_seq !== j) begin
                errors++; $display("FAIL ovf_drain: got v%0b seq %0d want v1 seq %0d", rec_valid, rec_seq, j);
            end
            tick();
        end
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b want 0", rec_valid); end
        ready = 0;
        rvfi = {mk(0, 0, 0, 0), mk(1, 0, 32'h200, 0)};
        tick();
        rvfi = '0;
        checks++; if (rec_seq !== 32'd10) begin errors++; $display("FAIL ovf_gap: got %0d want 10", rec_seq); end
    endtask

    task automatic test_simultaneous();
        int n;
        reset_dut();
        for (int c = 0; c < 4; c++) begin
            rvfi = {mk(c < 3, 0, 32'h300 + c, 0), mk(1, 0, 32'h400 + c, 0)};
            tick();
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL sim_full7: got %0b want 1", full); end
        ready = 1;
        rvfi = {mk(0, 0, 0, 0), mk(1, 0, 32'h500, 0)};
        tick();
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL sim_nodrop: got %0d want 0", drop_cnt); end
        checks++; if (rec_seq !== 32'd1 || full !== 1'b1) begin errors++; $display("FAIL sim_head: got seq %0d full %0b want 1/1", rec_seq, full); end
        ready = 0;
        rvfi = {mk(1, 0, 32'h600, 0), mk(1, 0, 32'h604, 0)};
        tick();
        rvfi = '0;
        checks++; if (drop_cnt !== 32'd2) begin errors++; $display("FAIL sim_drop2: got %0d want 2", drop_cnt); end
        ready = 1;
        n = 0;
        for (int b = 0; b < 20 && rec_valid; b++) begin
            checks++;
            if (rec_seq !== 32'd1 + n) begin errors++; $display("FAIL sim_seq: got %0d want %0d", rec_seq, 1 + n); end
            n++;
            tick();
        end
        checks++; if (n != 7) begin errors++; $display("FAIL sim_occ: got %0d want 7", n); end
    endtask

    task automatic test_flush();
        reset_dut();
        rvfi = {mk(1, 0, 32'h10, 0), mk(1, 0, 32'h14, 0)};
        tick();
        rvfi = {mk(0, 0, 0, 0), mk(1, 0, 32'h18, 0)};
        tick();
        flush = 1; ready = 1;
        rvfi = {mk(1, 0, 32'h20, 0), mk(1, 0, 32'h24, 0)};
        tick();
        flush = 0; ready = 0; rvfi = '0;
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", rec_valid); end
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL flush_drop: got %0d want 0", drop_cnt); end
        rvfi = {mk(0, 0, 0, 0), mk(1, 0, 32'h30, 0)};
        tick();
        rvfi = '0;
        checks++; if (rec_valid !== 1'b1 || rec_seq !== 32'd3) begin errors++; $display("FAIL flush_seq: got v%0b seq %0d want v1 seq 3", rec_valid, rec_seq); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            ready = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 59) == 0);
            rvfi = {mk($urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom, $urandom),
                    mk($urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom, $urandom)};
            tick();
            checks++;
            if (rec_valid !== (mq.size() != 0)) begin
                errors++; $display("FAIL rand_valid: cycle %0d got %0b want %0b", i, rec_valid, mq.size() != 0);
            end else if (mq.size() != 0) begin
                checks++;
                if (rec !== mq[0].rec || rec_seq !== mq[0].seq) begin
                    errors++; $display("FAIL rand_head: cycle %0d got %h/%0d want %h/%0d", i, rec, rec_seq, mq[0].rec, mq[0].seq);
                end
`ifdef RVFI_SER_TIMESTAMP_EN
                checks++;
                if (rec_time !== mq[0].tm) begin errors++; $display("FAIL rand_time: got %0d want %0d", rec_time, mq[0].tm); end
`endif
            end else begin
                checks++; if (rec !== '0) begin errors++; $display("FAIL rand_idle: got %h want 0", rec); end
            end
            checks++;
            if (drop_cnt !== m_drop || overflow !== m_ovf || full !== ((DEPTH - mq.size()) < NR)) begin
                errors++; $display("FAIL rand_status: cycle %0d got %0d/%0b/%0b want %0d/%0b/%0b", i, drop_cnt, overflow, full,
                                   m_drop, m_ovf, (DEPTH - mq.size()) < NR);
            end
        end
        flush = 0; rvfi = '0;
    endtask

    task automatic test_reset_midstream();
        reset_dut();
        rvfi = {mk(1, 0, 32'h40, 0), mk(1, 0, 32'h44, 0)};
        tick();
        rvfi = {mk(1, 0, 32'h48, 0), mk(1, 0, 32'h4C, 0)};
        tick();
        rvfi = '0;
        checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got %0b want 1", rec_valid); end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (rec_valid !== 0 || rec !== '0 || rec_seq !== 0 || drop_cnt !== 0 || overflow !== 0) begin
            errors++; $display("FAIL mid_async: got v%0b rec %h seq %0d drop %0d ovf %0b want all 0", rec_valid, rec, rec_seq, drop_cnt, overflow);
        end
        @(posedge clk); #1;
        rst_n = 1;
        rvfi = {mk(0, 0, 0, 0), mk(1, 0, 32'h50, 0)};
        tick();
        rvfi = '0;
        checks++; if (rec_valid !== 1'b1 || rec_seq !== 0) begin errors++; $display("FAIL mid_seq: got v%0b seq %0d want v1 seq 0", rec_valid, rec_seq); end
`ifdef RVFI_SER_TIMESTAMP_EN
        checks++; if (rec_time !== 0) begin errors++; $display("FAIL mid_time: got %0d want 0", rec_time); end
`endif
    endtask

    initial begin
        clk = 0;
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_sparse();
        test_overflow();
        test_simultaneous();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
